mux1hot_arb: RTL and testbench

- Parametrised successor to the 3-input one-hot mux: NUM_IN channels of WIDTH bits, each with a valid/ready/last handshake.
- Internal one-hot grant is either round-robin or fixed-priority; the grant selects one channel through an AND-OR one-hot mux into a single registered output stage.
- Multi-beat packets (in_last) hold the grant until the last beat, so packets are never interleaved.
- Sits in front of any shared single-consumer resource.

---
 rtl/mux1hot_arb.sv | 150 +++++++++++++++
 tb/tb_mux1hot_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux1hot_arb.sv
// mux1hot_arb: NUM_IN-channel valid/ready/last arbiter feeding a single
// registered output stage. Round-robin or fixed-priority arbitration picks a
// one-hot grant, an AND-OR mux selects the granted channel, and multi-beat
// packets keep the grant until their last beat so packets never interleave.
module mux1hot_arb #(
  parameter int WIDTH   = 3,
  parameter int NUM_IN  = 3,
  parameter int RR_MODE = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN-1:0]       in_last,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [WIDTH-1:0]        out_data,
  output logic [NUM_IN-1:0]       out_grant
);

  localparam int unsigned N  = NUM_IN;
  localparam int unsigned PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    ST_ARB,
    ST_LOCK
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_lock_idx;

  logic              w_load;
  logic [N-1:0]      w_grant;
  logic [PW-1:0]     w_gnt_idx;
  logic [PW-1:0]     w_ptr_next;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_mux_data;
  logic              w_mux_last;

  // Output stage can take a new beat when empty or being drained this cycle.
  assign w_load = ~out_valid | out_ready;

  // One-hot grant: locked channel, rotating search from r_ptr, or lowest index.
  always_comb begin
    logic         found;
    int unsigned  idx;
    w_grant = '0;
    found   = 1'b0;
    idx     = 0;
    if (r_state == ST_LOCK) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (PW'(i) == r_lock_idx) w_grant[i] = 1'b1;
      end
    end else if (RR_MODE != 0) begin
      for (int unsigned off = 0; off < N; off++) begin
        idx = 32'(r_ptr) + off;
        if (idx >= N) idx = idx - N;
        if (!found && in_valid[idx]) begin
          w_grant[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && in_valid[i]) begin
          w_grant[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // Encode the one-hot grant back to an index for the lock and pointer state.
  always_comb begin
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_grant[i]) w_gnt_idx = PW'(i);
    end
  end

  // Pointer moves one past the channel that just finished, wrapping to 0.
  always_comb begin
    if (w_gnt_idx == PW'(N - 1)) w_ptr_next = '0;
    else                         w_ptr_next = w_gnt_idx + 1'b1;
  end

  // AND-OR one-hot mux of data and last flag.
  always_comb begin
    w_mux_data = '0;
    w_mux_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      w_mux_data = w_mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
      w_mux_last = w_mux_last | (in_last[i] & w_grant[i]);
    end
  end

  // Ready only to the granted, requesting channel while the stage can load.
  assign in_ready = {N{w_load}} & w_grant & in_valid;
  assign w_xfer   = |in_ready;

  // Registered output stage: load on transfer, drain when consumed, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_grant <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        out_valid <= 1'b1;
        out_data  <= w_mux_data;
        out_last  <= w_mux_last;
        out_grant <= w_grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Arbitration FSM: lock on a non-last beat, release and advance ptr on last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_ARB;
      r_ptr      <= '0;
      r_lock_idx <= '0;
    end else if (w_xfer) begin
      case (r_state)
        ST_ARB: begin
          if (w_mux_last) begin
            r_ptr <= w_ptr_next;
          end else begin
            r_state    <= ST_LOCK;
            r_lock_idx <= w_gnt_idx;
          end
        end
        ST_LOCK: begin
          if (w_mux_last) begin
            r_state <= ST_ARB;
            r_ptr   <= w_ptr_next;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mux1hot_arb.sv
// Self-checking bench for mux1hot_arb: a round-robin and a fixed-priority
// instance share stimulus; a behavioural model predicts both every cycle and
// directed literal checks pin the expected sequences.
module tb_mux1hot_arb;

  localparam int W = 3;
  localparam int N = 3;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   valid;
  logic [N-1:0]   last;
  logic [N*W-1:0] data;
  logic           oready;

  logic [N-1:0] rr_rdy, fp_rdy;
  logic         rr_ov, fp_ov, rr_ol, fp_ol;
  logic [W-1:0] rr_od, fp_od;
  logic [N-1:0] rr_og, fp_og;

  int n_err = 0;
  int n_chk = 0;

  mux1hot_arb #(.WIDTH(W), .NUM_IN(N), .RR_MODE(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .in_valid(valid), .in_ready(rr_rdy),
    .in_last(last), .in_data(data), .out_valid(rr_ov), .out_ready(oready),
    .out_last(rr_ol), .out_data(rr_od), .out_grant(rr_og)
  );

  mux1hot_arb #(.WIDTH(W), .NUM_IN(N), .RR_MODE(0)) u_fp (
    .clk(clk), .reset_n(reset_n), .in_valid(valid), .in_ready(fp_rdy),
    .in_last(last), .in_data(data), .out_valid(fp_ov), .out_ready(oready),
    .out_last(fp_ol), .out_data(fp_od), .out_grant(fp_og)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel that would transfer given arbitration state, or -1 for none.
  function automatic int pick(input bit rr, input bit lk, input int ch,
                              input int ptr, input logic [N-1:0] v);
    if (lk) return v[ch] ? ch : -1;
    for (int off = 0; off < N; off++) begin
      int i;
      i = rr ? (ptr + off) % N : off;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit           mv[2];
  logic [W-1:0] md[2];
  bit           ml[2];
  logic [N-1:0] mg[2];
  bit           mlk[2];
  int           mch[2];
  int           mptr[2];
  int           eg[2];
  bit           eld[2];
  logic [N-1:0] erdy[2];

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      eg[m]   = pick(m == 0, mlk[m], mch[m], mptr[m], valid);
      eld[m]  = !mv[m] || oready;
      erdy[m] = (eld[m] && eg[m] >= 0) ? N'(1 << eg[m]) : '0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < 2; m++) begin
        mv[m] <= 0; md[m] <= '0; ml[m] <= 0; mg[m] <= '0;
        mlk[m] <= 0; mch[m] <= 0; mptr[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (eld[m] && eg[m] >= 0) begin
          mv[m] <= 1;
          md[m] <= data[eg[m]*W +: W];
          ml[m] <= last[eg[m]];
          mg[m] <= N'(1 << eg[m]);
          if (last[eg[m]]) begin
            mlk[m]  <= 0;
            mptr[m] <= (eg[m] + 1) % N;
          end else begin
            mlk[m] <= 1;
            mch[m] <= eg[m];
          end
        end else if (eld[m]) begin
          mv[m] <= 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("rr_ready", int'(rr_rdy), int'(erdy[0]));
    chk("rr_valid", int'(rr_ov), int'(mv[0]));
    chk("rr_data", int'(rr_od), int'(md[0]));
    chk("rr_last", int'(rr_ol), int'(ml[0]));
    chk("rr_grant", int'(rr_og), int'(mg[0]));
    chk("fp_ready", int'(fp_rdy), int'(erdy[1]));
    chk("fp_valid", int'(fp_ov), int'(mv[1]));
    chk("fp_data", int'(fp_od), int'(md[1]));
    chk("fp_last", int'(fp_ol), int'(ml[1]));
    chk("fp_grant", int'(fp_og), int'(mg[1]));
    chk("rr_ready_onehot0", int'($onehot0(rr_rdy)), 1);
    chk("fp_ready_onehot0", int'($onehot0(fp_rdy)), 1);
    if (rr_ov) chk("rr_grant_onehot", int'($onehot(rr_og)), 1);
    if (fp_ov) chk("fp_grant_onehot", int'($onehot(fp_og)), 1);
  end

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    valid   = '0;
    last    = '0;
    data    = {3'b010, 3'b001, 3'b000};
    oready  = 1'b1;

    // Reset state
    drive_slot();
    @(negedge clk);
    chk("lit_reset_valid", int'(rr_ov), 0);
    chk("lit_reset_data", int'(rr_od), 0);
    chk("lit_reset_grant", int'(rr_og), 0);
    drive_slot();
    reset_n = 1'b1;
    valid   = 3'b111;
    last    = 3'b111;

    // Round-robin fairness / fixed priority with all channels requesting
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("lit_rr_fair_ready", int'(rr_rdy), 1 << (k % 3));
      chk("lit_fp_ready", int'(fp_rdy), 1);
      if (k > 0) begin
        chk("lit_rr_fair_grant", int'(rr_og), 1 << ((k - 1) % 3));
        chk("lit_rr_fair_data", int'(rr_od), (k - 1) % 3);
        chk("lit_fp_grant", int'(fp_og), 1);
      end
      drive_slot();
    end

    // Single beat on channel 1
    valid = 3'b010;
    @(negedge clk);
    chk("lit_rr_fair_grant_last", int'(rr_og), 3'b100);
    chk("lit_rr_fair_data_last", int'(rr_od), 3'b010);
    chk("lit_single_ready", int'(rr_rdy), 3'b010);
    drive_slot();
    valid = 3'b000;
    @(negedge clk);
    chk("lit_single_valid", int'(rr_ov), 1);
    chk("lit_single_data", int'(rr_od), 3'b001);
    chk("lit_single_grant", int'(rr_og), 3'b010);
    chk("lit_single_last", int'(rr_ol), 1);
    drive_slot();
    @(negedge clk);
    chk("lit_idle_drain", int'(rr_ov), 0);
    chk("lit_idle_hold_data", int'(rr_od), 3'b001);

    // Packet of 3 beats on channel 2 with a mid-packet gap
    drive_slot();
    valid = 3'b111;
    last  = 3'b011;
    @(negedge clk);
    chk("lit_pkt_b1_ready", int'(rr_rdy), 3'b100);
    drive_slot();
    valid = 3'b011;
    @(negedge clk);
    chk("lit_pkt_gap_ready", int'(rr_rdy), 3'b000);
    chk("lit_pkt_b1_grant", int'(rr_og), 3'b100);
    chk("lit_pkt_b1_last", int'(rr_ol), 0);
    drive_slot();
    valid = 3'b111;
    @(negedge clk);
    chk("lit_pkt_b2_ready", int'(rr_rdy), 3'b100);
    chk("lit_pkt_gap_bubble", int'(rr_ov), 0);
    drive_slot();
    last = 3'b111;
    @(negedge clk);
    chk("lit_pkt_b3_ready", int'(rr_rdy), 3'b100);
    chk("lit_pkt_b2_grant", int'(rr_og), 3'b100);
    drive_slot();
    @(negedge clk);
    chk("lit_pkt_wrap_ready", int'(rr_rdy), 3'b001);
    chk("lit_pkt_b3_grant", int'(rr_og), 3'b100);
    chk("lit_pkt_b3_last", int'(rr_ol), 1);

    // Backpressure for 4 cycles
    drive_slot();
    oready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_bp_ready", int'(rr_rdy), 0);
      chk("lit_bp_fp_ready", int'(fp_rdy), 0);
      chk("lit_bp_grant", int'(rr_og), 3'b001);
      chk("lit_bp_data", int'(rr_od), 3'b000);
      chk("lit_bp_valid", int'(rr_ov), 1);
      drive_slot();
    end
    oready = 1'b1;
    @(negedge clk);
    chk("lit_bp_release_ready", int'(rr_rdy), 3'b010);
    drive_slot();
    valid = 3'b100;
    last  = 3'b000;
    @(negedge clk);
    chk("lit_bp_nobubble_valid", int'(rr_ov), 1);
    chk("lit_bp_nobubble_grant", int'(rr_og), 3'b010);
    chk("lit_rst_pkt_ready", int'(rr_rdy), 3'b100);

    // Asynchronous reset in the middle of a locked packet
    drive_slot();
    @(negedge clk);
    chk("lit_rst_pre_valid", int'(rr_ov), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("lit_rst_async_valid", int'(rr_ov), 0);
    chk("lit_rst_async_data", int'(rr_od), 0);
    chk("lit_rst_async_grant", int'(rr_og), 0);
    drive_slot();
    drive_slot();
    reset_n = 1'b1;
    valid   = 3'b111;
    last    = 3'b111;
    @(negedge clk);
    chk("lit_rst_restart_ready", int'(rr_rdy), 3'b001);
    drive_slot();
    valid = 3'b000;
    @(negedge clk);
    chk("lit_rst_restart_grant", int'(rr_og), 3'b001);
    drive_slot();
    drive_slot();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
